// File: rtl/pipeline4_mem_wb_pkg.sv
// Shared processor definitions for the MEM/WB stage: widths, opcodes and opcode classification.
// Optional feature: MEMWB_TIMEOUT_EN (see pipeline4_mem_wb.sv).
package pipeline4_mem_wb_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int MEM_W_DEF      = 16;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF     = 6;

  localparam logic [CTRL_W_DEF-1:0] OP_NOP    = 6'd0;
  localparam logic [CTRL_W_DEF-1:0] OP_ADD    = 6'd1;
  localparam logic [CTRL_W_DEF-1:0] OP_SUB    = 6'd2;
  localparam logic [CTRL_W_DEF-1:0] OP_MUL    = 6'd3;
  localparam logic [CTRL_W_DEF-1:0] OP_DIV    = 6'd4;
  localparam logic [CTRL_W_DEF-1:0] OP_AND    = 6'd5;
  localparam logic [CTRL_W_DEF-1:0] OP_OR     = 6'd6;
  localparam logic [CTRL_W_DEF-1:0] OP_NOT    = 6'd7;
  localparam logic [CTRL_W_DEF-1:0] OP_LW     = 6'd8;
  localparam logic [CTRL_W_DEF-1:0] OP_SW     = 6'd9;
  localparam logic [CTRL_W_DEF-1:0] OP_LW_IMM = 6'd10;
  localparam logic [CTRL_W_DEF-1:0] OP_CMP    = 6'd11;
  localparam logic [CTRL_W_DEF-1:0] OP_JR     = 6'd12;
  localparam logic [CTRL_W_DEF-1:0] OP_JPC    = 6'd13;
  localparam logic [CTRL_W_DEF-1:0] OP_BRFL   = 6'd14;
  localparam logic [CTRL_W_DEF-1:0] OP_CALL   = 6'd15;
  localparam logic [CTRL_W_DEF-1:0] OP_RET    = 6'd16;

  // Opcodes whose execute-stage result goes straight to the register file.
  function automatic logic is_alu_wb(input logic [CTRL_W_DEF-1:0] op);
    case (op)
      OP_LW_IMM, OP_ADD, OP_SUB, OP_MUL,
      OP_DIV, OP_AND, OP_OR, OP_NOT: is_alu_wb = 1'b1;
      default:                       is_alu_wb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline4_mem_wb_watchdog.sv
// memwb_watchdog: counts MEM cycles without ack and flags expiry on the cycle the limit is reached.
// Only instantiated when MEMWB_TIMEOUT_EN is defined.
module memwb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_i || start_i) begin
      cnt_q <= '0;
    end else if (busy_i && !ack_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expires on the edge ending the TIMEOUT_CYCLES-th unacknowledged MEM cycle; ack wins.
  assign expire_o = busy_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pipeline4_mem_wb.sv
// Pipeline stage 4: data-memory load/store over req/ack and register-file write-back.
// Optional MEMWB_TIMEOUT_EN adds a watchdog that abandons stuck transfers and sets sticky mem_err.
module pipeline4_mem_wb
  import pipeline4_mem_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int MEM_WIDTH      = MEM_W_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W_DEF,
  parameter int CTRL_WIDTH     = CTRL_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic                      mem_we,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [MEM_WIDTH-1:0]      addr,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [MEM_WIDTH-1:0]      dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0]     rf_data,
  output logic                      mem_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_WB = 2'd2} state_t;

  state_t                    state_q;
  logic                      req_q, dwe_q, rf_we_q;
  logic [MEM_WIDTH-1:0]      daddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q, rf_data_q;
  logic [REG_ADDR_WIDTH-1:0] ld_reg_q, rf_addr_q;
  logic                      start_mem, expire;

  assign start_mem = (state_q == S_IDLE) && (mem_we || (ctrl_in == OP_LW));

`ifdef MEMWB_TIMEOUT_EN
  logic err_q;

  memwb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_in   (clk_in),
    .rst_n_i  (RST),
    .start_i  (start_mem),
    .busy_i   (state_q == S_MEM),
    .ack_i    (dmem_ack),
    .expire_o (expire)
  );

  always_ff @(posedge clk_in) begin
    if (!RST)        err_q <= 1'b0;
    else if (expire) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  assign expire  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      wdata_q   <= '0;
      ld_reg_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_mem) begin
            state_q  <= S_MEM;
            req_q    <= 1'b1;
            dwe_q    <= mem_we;
            daddr_q  <= addr;
            wdata_q  <= data;
            ld_reg_q <= reg_addr;
          end else if (is_alu_wb(ctrl_in) && (reg_addr != '0)) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= reg_addr;
            rf_data_q <= data;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            req_q <= 1'b0;
            if (dwe_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WB;
              // r0 is read-only: the load completes but nothing is written.
              if (ld_reg_q != '0) begin
                rf_we_q   <= 1'b1;
                rf_addr_q <= ld_reg_q;
                rf_data_q <= dmem_rdata;
              end
            end
          end else if (expire) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall      = (state_q != S_IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;

endmodule
